// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if
//   AHB-Lite bus signals seen by one SRAM responder.
//   master modport : drives the address/control/write-data side
//                    and the bus-level HREADY (mux output).
//   slave modport  : drives HREADYOUT, HRDATA and HRESP back.
interface ahb_sram_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic [1:0]  HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      input  HREADYOUT, HRDATA, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
      output HREADYOUT, HRDATA, HRESP
   );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite responder around a word-organised SRAM with byte/halfword/word
//   access, WAIT_STATES wait cycles per OKAY transfer and the two-cycle
//   ERROR response for illegal size, misalignment or out-of-range address.
//
//   Ports
//     HCLK    : clock, all state changes on the rising edge
//     HRESET  : synchronous reset, active high
//     bus     : AHB-Lite slave modport (HSEL/HADDR/HTRANS/HWRITE/HSIZE/
//               HWDATA/HREADY in, HREADYOUT/HRDATA/HRESP out)
//
//   state  | meaning
//   -------+-----------------------------------------------------
//   IDLE   | no data phase pending, zero-wait OKAY
//   WAIT   | data phase stalled, wait counter running down
//   DONE   | last data-phase cycle: read data out / write commits
//   ERR1   | first ERROR cycle, HREADYOUT low
//   ERR2   | second ERROR cycle, HREADYOUT high
module ahb_sram_slave #(
   parameter int MEM_BYTES   = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic             HCLK,
   input  logic             HRESET,
   ahb_sram_slave_if.slave  bus
);

   localparam int         AW    = $clog2(MEM_BYTES);
   localparam int         WORDS = MEM_BYTES / 4;
   localparam int         WIDX  = (AW > 2) ? AW - 2 : 1;
   localparam logic [2:0] WS    = 3'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DONE,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t          state, state_nxt;
   logic [2:0]      wait_cnt, wait_cnt_nxt;
   logic [AW-1:0]   d_addr;
   logic            d_write;
   logic [1:0]      d_size;

   logic            hready_int;
   logic [1:0]      hresp_int;
   logic            accept;
   logic            addr_err;
   logic [3:0]      byte_en;
   logic [WIDX-1:0] word_idx;
   logic [31:0]     mem [WORDS];

   // Address-phase qualification. hready_int is folded in so a stray HREADY
   // during a stalled data phase can never start a second transfer.
   assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hready_int;

   assign addr_err = (bus.HSIZE > 3'b010)
                   | ((bus.HSIZE == 3'b001) & bus.HADDR[0])
                   | ((bus.HSIZE == 3'b010) & (|bus.HADDR[1:0]))
                   | (|(bus.HADDR >> AW));

   always_comb begin
      hready_int = 1'b1;
      hresp_int  = 2'b00;
      unique case (state)
         S_WAIT:  hready_int = 1'b0;
         S_ERR1: begin
            hready_int = 1'b0;
            hresp_int  = 2'b01;
         end
         S_ERR2:  hresp_int = 2'b01;
         default: ;
      endcase
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      unique case (state)
         S_WAIT: begin
            wait_cnt_nxt = wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) state_nxt = S_DONE;
         end
         S_ERR1:  state_nxt = S_ERR2;
         S_ERR2:  state_nxt = S_IDLE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      // accept is only possible in IDLE/DONE/ERR2, so it overrides the
      // fall-back to IDLE and gives back-to-back pipelining.
      if (accept) begin
         if (addr_err) begin
            state_nxt = S_ERR1;
         end else if (WS == 3'd0) begin
            state_nxt = S_DONE;
         end else begin
            state_nxt    = S_WAIT;
            wait_cnt_nxt = WS;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= S_IDLE;
         wait_cnt <= 3'd0;
         d_addr   <= '0;
         d_write  <= 1'b0;
         d_size   <= 2'b00;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (accept) begin
            d_addr  <= bus.HADDR[AW-1:0];
            d_write <= bus.HWRITE;
            d_size  <= bus.HSIZE[1:0];
         end
      end
   end

   assign word_idx = WIDX'(d_addr >> 2);

   always_comb begin
      byte_en = 4'b1111;
      unique case (d_size)
         2'b00:   byte_en = 4'b0001 << d_addr[1:0];
         2'b01:   byte_en = d_addr[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   end

   // Storage is never reset; a reset edge landing on DONE drops the write.
   always_ff @(posedge HCLK) begin
      if (!HRESET && (state == S_DONE) && d_write) begin
         for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) mem[word_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end

   // Asynchronous array read: a write committed on the edge that enters a
   // read's DONE cycle is already visible, so no forwarding path is needed.
   assign bus.HRDATA    = ((state == S_DONE) && !d_write) ? mem[word_idx] : 32'h0;
   assign bus.HREADYOUT = hready_int;
   assign bus.HRESP     = hresp_int;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Two responders (WAIT_STATES=1 and WAIT_STATES=0) on separate buses; the
//   bench works one of them at a time. Issued transfers push their expected
//   response into a queue, a negedge monitor pops and checks every cycle.
module tb_ahb_sram_slave;

   localparam int WS_A = 1;
   localparam int WS_B = 0;

   typedef struct packed {
      logic        err;
      logic        wr;
      logic [31:0] rdata;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        dut_sel = 1'b0;
   logic        mon_en = 1'b0;
   logic        hsel = 1'b0;
   logic [31:0] haddr = '0;
   logic [1:0]  htrans = 2'b00;
   logic        hwrite = 1'b0;
   logic [2:0]  hsize = 3'b000;
   logic [31:0] hwdata = '0;

   int n_vec = 0;
   int n_bad = 0;

   logic [7:0] mdl [2][64];
   exp_t       exq[$];
   exp_t       cur;
   logic       pend = 1'b0;
   int         cyc = 0;

   always #5 clk = ~clk;

   ahb_sram_slave_if bus0 ();
   ahb_sram_slave_if bus1 ();

   assign bus0.HSEL   = hsel & ~dut_sel;
   assign bus1.HSEL   = hsel &  dut_sel;
   assign bus0.HADDR  = haddr;   assign bus1.HADDR  = haddr;
   assign bus0.HTRANS = htrans;  assign bus1.HTRANS = htrans;
   assign bus0.HWRITE = hwrite;  assign bus1.HWRITE = hwrite;
   assign bus0.HSIZE  = hsize;   assign bus1.HSIZE  = hsize;
   assign bus0.HWDATA = hwdata;  assign bus1.HWDATA = hwdata;
   assign bus0.HREADY = bus0.HREADYOUT;
   assign bus1.HREADY = bus1.HREADYOUT;

   ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(WS_A)) u_dut_a (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus0)
   );

   ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(WS_B)) u_dut_b (
      .HCLK   (clk),
      .HRESET (rst),
      .bus    (bus1)
   );

   wire        rdy_m   = dut_sel ? bus1.HREADYOUT : bus0.HREADYOUT;
   wire [1:0]  resp_m  = dut_sel ? bus1.HRESP     : bus0.HRESP;
   wire [31:0] rdata_m = dut_sel ? bus1.HRDATA    : bus0.HRDATA;

   function automatic void check(string name, logic [63:0] act, logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Monitor: one check per cycle. Outside a data phase the responder must
   // look idle; inside, the expected cycle shape follows from the error
   // flag and the wait-state count of the selected instance.
   always @(negedge clk) begin
      logic [34:0] act_v, exp_v;
      logic        last;
      int          ws;
      if (mon_en) begin
         ws    = dut_sel ? WS_B : WS_A;
         act_v = {rdy_m, resp_m, rdata_m};
         if (pend) begin
            cyc++;
            last = cur.err ? (cyc == 2) : (cyc == ws + 1);
            if (cur.err) exp_v = {last, 2'b01, 32'h0};
            else         exp_v = {last, 2'b00, (last && !cur.wr) ? cur.rdata : 32'h0};
            check(cur.err ? "err_phase" : (cur.wr ? "write_phase" : "read_phase"),
                  64'(act_v), 64'(exp_v));
            if (last) pend = 1'b0;
         end else begin
            check("idle_cycle", 64'(act_v), 64'({1'b1, 2'b00, 32'h0}));
         end
         if (rst) begin
            pend = 1'b0;
            exq.delete();
         end else if (hsel && htrans[1] && rdy_m) begin
            if (exq.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL accept_unexpected: got accept, expected none (t=%0t)", $time);
            end else begin
               cur  = exq.pop_front();
               pend = 1'b1;
               cyc  = 0;
            end
         end
      end
   end

   // Reference: byte-addressed model, legality from the transfer rules.
   function automatic exp_t model_xfer(int s, logic w, logic [31:0] a, logic [2:0] sz,
                                       logic [31:0] d);
      exp_t e;
      int   n, base, ai;
      n       = 1 << sz;
      e.err   = !((sz <= 3'd2) && ((a % n) == 0) && ((a >> 10) == 0));
      e.wr    = w;
      e.rdata = 32'h0;
      if (!e.err) begin
         ai = int'(a);
         if (w) begin
            for (int i = 0; i < n; i++) mdl[s][ai+i] = d[8*((ai+i)%4) +: 8];
         end else begin
            base    = ai - (ai % 4);
            e.rdata = {mdl[s][base+3], mdl[s][base+2], mdl[s][base+1], mdl[s][base]};
         end
      end
      return e;
   endfunction

   // Called just after a rising edge. Presents the address phase, waits for
   // it to be accepted, then drives write data for the data phase.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d);
      int guard;
      exq.push_back(model_xfer(int'(dut_sel), w, a, sz, d));
      hsel   = 1'b1;
      haddr  = a;
      htrans = 2'b10;
      hwrite = w;
      hsize  = sz;
      guard  = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!rdy_m && guard < 32);
      if (!rdy_m) begin
         n_vec++;
         n_bad++;
         $display("FAIL hready_timeout: got HREADYOUT=0 for %0d cycles, expected 1", guard);
      end
      @(posedge clk);
      #1;
      hwdata = d;
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   // One bus slot that must not start a transfer.
   task automatic nop(input int kind);
      int guard;
      hsel   = (kind != 0);
      htrans = (kind == 0) ? 2'b10 : ((kind == 1) ? 2'b00 : 2'b01);
      haddr  = 32'($urandom_range(0, 63));
      hwrite = 1'($urandom);
      hsize  = 3'($urandom_range(0, 2));
      guard  = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!rdy_m && guard < 32);
      @(posedge clk);
      #1;
      hsel   = 1'b0;
      htrans = 2'b00;
   endtask

   task automatic idle(input int n);
      hsel   = 1'b0;
      htrans = 2'b00;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic init_region();
      for (int i = 0; i < 16; i++) xfer(1'b1, 32'(4*i), 3'b010, $urandom);
      idle(3);
   endtask

   task automatic random_run(input int n);
      logic [31:0] a;
      logic [2:0]  sz;
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            0: nop(int'($urandom_range(0, 2)));
            1: idle(1);
            default: begin
               sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                : 3'($urandom_range(0, 2));
               a  = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_0400)
                                                : 32'($urandom_range(0, 63));
               xfer(1'($urandom), a, sz, $urandom);
            end
         endcase
      end
      idle(4);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish by 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] saved [4];

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_a", 64'({bus0.HREADYOUT, bus0.HRESP, bus0.HRDATA}), 64'({1'b1, 2'b00, 32'h0}));
      check("reset_b", 64'({bus1.HREADYOUT, bus1.HRESP, bus1.HRDATA}), 64'({1'b1, 2'b00, 32'h0}));
      rst    = 1'b0;
      mon_en = 1'b1;

      // ---- one wait state ----
      dut_sel = 1'b0;
      init_region();
      xfer(1'b1, 32'h010, 3'b010, 32'hDEAD_BEEF);
      xfer(1'b0, 32'h010, 3'b010, 32'h0);
      idle(2);
      xfer(1'b1, 32'h010, 3'b010, 32'h1122_3344);
      xfer(1'b1, 32'h013, 3'b000, 32'h5500_0000);
      xfer(1'b0, 32'h010, 3'b010, 32'h0);
      xfer(1'b1, 32'h010, 3'b001, 32'h0000_AAAA);
      xfer(1'b0, 32'h010, 3'b010, 32'h0);
      xfer(1'b0, 32'h402, 3'b010, 32'h0);
      xfer(1'b1, 32'h012, 3'b010, 32'hFFFF_FFFF);
      xfer(1'b1, 32'h011, 3'b001, 32'hFFFF_FFFF);
      xfer(1'b1, 32'h010, 3'b011, 32'hFFFF_FFFF);
      xfer(1'b0, 32'h010, 3'b010, 32'h0);
      xfer(1'b0, 32'h012, 3'b001, 32'h0);
      idle(2);

      // reset during the wait cycle of a write: nothing may be committed
      for (int i = 0; i < 4; i++) saved[i] = mdl[0][48+i];
      xfer(1'b1, 32'h030, 3'b010, 32'h1234_5678);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mdl[0][48+i] = saved[i];
      idle(1);
      xfer(1'b0, 32'h030, 3'b010, 32'h0);
      idle(2);

      random_run(250);

      // ---- zero wait states ----
      dut_sel = 1'b1;
      idle(1);
      init_region();
      xfer(1'b1, 32'h020, 3'b010, 32'h0000_CAFE);
      xfer(1'b0, 32'h020, 3'b010, 32'h0);
      xfer(1'b1, 32'h022, 3'b001, 32'h5A5A_0000);
      xfer(1'b0, 32'h020, 3'b000, 32'h0);
      xfer(1'b0, 32'h402, 3'b010, 32'h0);
      xfer(1'b0, 32'h020, 3'b010, 32'h0);
      idle(2);
      random_run(250);

      idle(4);
      check("drain_pending", 64'(pend), 64'(0));
      check("drain_queue", 64'(exq.size()), 64'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
